// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: FSM encoding, status_err bit positions,
// frame constants and the reflected CRC-32 byte update.
package eth_pkg;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_PREAMBLE = 4'd1;
   localparam logic [3:0] ST_SFD      = 4'd2;
   localparam logic [3:0] ST_DST      = 4'd3;
   localparam logic [3:0] ST_SRC      = 4'd4;
   localparam logic [3:0] ST_TYPE     = 4'd5;
   localparam logic [3:0] ST_VTAG     = 4'd6;
   localparam logic [3:0] ST_PAYLOAD  = 4'd7;
   localparam logic [3:0] ST_REPORT   = 4'd8;

   localparam int ERR_PREAMBLE = 0;
   localparam int ERR_SFD      = 1;
   localparam int ERR_RUNT     = 2;
   localparam int ERR_GIANT    = 3;
   localparam int ERR_CRC      = 4;
   localparam int ERR_TRUNC    = 5;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [15:0] TPID_VLAN     = 16'h8100;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   // Reflected IEEE 802.3 CRC, data consumed LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_gen.sv
// Byte-serial Ethernet CRC-32 with per-frame clear; crc_out is the final
// (inverted) value, transmitted crc_out[7:0] first.
module crc32_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);
   import eth_pkg::*;

   logic [31:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr)     crc_d = CRC32_INIT;
      else if (en) crc_d = crc32_byte(crc_q, data);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= CRC32_INIT;
      else        crc_q <= crc_d;
   end

   assign crc_out = ~crc_q;

endmodule

// File: rtl/frame_rx_checker.sv
// Ethernet frame receive checker: header capture, length/FCS/framing checks,
// held status report and statistics. VLAN parsing under FRAME_RX_CHECKER_VLAN_EN.
module frame_rx_checker #(
   parameter int MIN_PAYLOAD  = 46,
   parameter int MAX_PAYLOAD  = 1500,
   parameter int CNT_WIDTH    = 16,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   input  logic                 s_sop,
   input  logic                 s_eop,
   output logic                 s_ready,
   output logic [47:0]          dest_mac,
   output logic [47:0]          src_mac,
   output logic [15:0]          ether_type,
   output logic                 hdr_valid,
   output logic                 vlan_present,
   output logic [15:0]          vlan_tci,
   output logic                 status_valid,
   input  logic                 status_ready,
   output logic [5:0]           status_err,
   output logic [10:0]          payload_len,
   output logic [CNT_WIDTH-1:0] frames_ok,
   output logic [CNT_WIDTH-1:0] frames_err
);
   import eth_pkg::*;

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
   localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);

   logic [3:0]           state_q, state_d;
   logic [7:0]           idx_q, idx_d;
   logic [10:0]          cnt_q, cnt_d, cnt_nxt;
   logic [5:0]           err_q, err_d;
   logic                 chk_q, chk_d, rdy_q, rdy_d, hdr_q, hdr_d;
   logic [47:0]          dst_q, dst_d, src_q, src_d;
   logic [15:0]          type_q, type_d;
   logic [31:0]          dly_q, dly_d, crc_out;
   logic [CNT_WIDTH-1:0] ok_q, ok_d, bad_q, bad_d;
   logic                 acc, crc_clr, crc_en;
`ifdef FRAME_RX_CHECKER_VLAN_EN
   logic [15:0]          tci_q, tci_d;
   logic                 vlan_q, vlan_d;
`endif

   function automatic logic [10:0] len_of(input logic [10:0] cnt);
      return (cnt < 11'd4) ? 11'd0 : cnt - 11'd4;
   endfunction

   assign acc     = s_valid & rdy_q;
   assign cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 11'd1;

   always_comb begin
      state_d = state_q; idx_d = idx_q; cnt_d = cnt_q; err_d = err_q;
      chk_d = chk_q; hdr_d = 1'b0; dst_d = dst_q; src_d = src_q;
      type_d = type_q; dly_d = dly_q; ok_d = ok_q; bad_d = bad_q;
      crc_clr = 1'b0; crc_en = 1'b0;
`ifdef FRAME_RX_CHECKER_VLAN_EN
      tci_d = tci_q; vlan_d = vlan_q;
`endif
      case (state_q)
         ST_IDLE: if (acc && s_sop) begin
            crc_clr = 1'b1; err_d = '0; chk_d = 1'b0; cnt_d = '0; idx_d = 8'd1;
`ifdef FRAME_RX_CHECKER_VLAN_EN
            tci_d = '0; vlan_d = 1'b0;
`endif
            err_d[ERR_PREAMBLE] = (s_data != PREAMBLE_BYTE);
            if (s_eop) begin
               err_d[ERR_TRUNC] = 1'b1; state_d = ST_REPORT;
            end else begin
               state_d = (PREAMBLE_LEN <= 1) ? ST_SFD : ST_PREAMBLE;
            end
         end
         ST_REPORT: if (status_ready) begin
            state_d = ST_IDLE;
            if (status_err == 6'd0) ok_d  = (&ok_q)  ? ok_q  : ok_q + 1'b1;
            else                    bad_d = (&bad_q) ? bad_q : bad_q + 1'b1;
         end
         default: if (acc) begin
            if (s_sop) begin
               // A new frame mid-flight aborts the current one; the new one is dropped.
               err_d[ERR_TRUNC] = 1'b1; state_d = ST_REPORT;
            end else begin
               if (state_q >= ST_DST) begin
                  dly_d  = {s_data, dly_q[31:8]};
                  crc_en = !(state_q == ST_DST && idx_q < 8'd4);
               end
               idx_d = idx_q + 8'd1;
               case (state_q)
                  ST_PREAMBLE: begin
                     if (s_data != PREAMBLE_BYTE) err_d[ERR_PREAMBLE] = 1'b1;
                     if (idx_q == PRE_LAST) state_d = ST_SFD;
                  end
                  ST_SFD: begin
                     if (s_data != SFD_BYTE) err_d[ERR_SFD] = 1'b1;
                     state_d = ST_DST; idx_d = '0;
                  end
                  ST_DST: begin
                     dst_d = {dst_q[39:0], s_data};
                     if (idx_q == 8'd5) begin state_d = ST_SRC; idx_d = '0; end
                  end
                  ST_SRC: begin
                     src_d = {src_q[39:0], s_data};
                     if (idx_q == 8'd5) begin state_d = ST_TYPE; idx_d = '0; end
                  end
                  ST_TYPE: begin
                     type_d = {type_q[7:0], s_data};
                     if (idx_q == 8'd1) begin
                        state_d = ST_PAYLOAD; hdr_d = 1'b1;
`ifdef FRAME_RX_CHECKER_VLAN_EN
                        if ({type_q[7:0], s_data} == TPID_VLAN) begin
                           state_d = ST_VTAG; hdr_d = 1'b0; idx_d = '0;
                        end
`endif
                     end
                  end
`ifdef FRAME_RX_CHECKER_VLAN_EN
                  ST_VTAG: begin
                     if (idx_q < 8'd2) tci_d  = {tci_q[7:0], s_data};
                     else              type_d = {type_q[7:0], s_data};
                     if (idx_q == 8'd3) begin
                        state_d = ST_PAYLOAD; vlan_d = 1'b1; hdr_d = 1'b1;
                     end
                  end
`endif
                  default: cnt_d = cnt_nxt;
               endcase
               if (s_eop) begin
                  state_d = ST_REPORT;
                  if (state_q == ST_PAYLOAD) begin
                     chk_d = 1'b1;
                     err_d[ERR_RUNT]  = (len_of(cnt_nxt) < MIN_LEN);
                     err_d[ERR_GIANT] = (len_of(cnt_nxt) > MAX_LEN);
                  end else begin
                     err_d[ERR_TRUNC] = 1'b1; hdr_d = 1'b0;
                  end
               end
            end
         end
      endcase
      rdy_d = (state_d != ST_REPORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE; idx_q <= '0; cnt_q <= '0; err_q <= '0;
         chk_q <= 1'b0; rdy_q <= 1'b0; hdr_q <= 1'b0;
         dst_q <= '0; src_q <= '0; type_q <= '0; dly_q <= '0;
         ok_q <= '0; bad_q <= '0;
      end else begin
         state_q <= state_d; idx_q <= idx_d; cnt_q <= cnt_d; err_q <= err_d;
         chk_q <= chk_d; rdy_q <= rdy_d; hdr_q <= hdr_d;
         dst_q <= dst_d; src_q <= src_d; type_q <= type_d; dly_q <= dly_d;
         ok_q <= ok_d; bad_q <= bad_d;
      end
   end

`ifdef FRAME_RX_CHECKER_VLAN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tci_q <= '0; vlan_q <= 1'b0;
      end else begin
         tci_q <= tci_d; vlan_q <= vlan_d;
      end
   end
   assign vlan_tci     = tci_q;
   assign vlan_present = vlan_q;
`else
   assign vlan_tci     = '0;
   assign vlan_present = 1'b0;
`endif

   crc32_gen u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (crc_clr),
      .en      (crc_en),
      .data    (dly_q[7:0]),
      .crc_out (crc_out)
   );

   // After the FCS the delay line holds exactly the received FCS, aligned with crc_out.
   assign status_err   = {err_q[ERR_TRUNC], err_q[ERR_CRC] | (chk_q && (crc_out != dly_q)), err_q[3:0]};
   assign status_valid = (state_q == ST_REPORT);
   assign s_ready      = rdy_q;
   assign hdr_valid    = hdr_q;
   assign payload_len  = len_of(cnt_q);
   assign dest_mac     = dst_q;
   assign src_mac      = src_q;
   assign ether_type   = type_q;
   assign frames_ok    = ok_q;
   assign frames_err   = bad_q;

endmodule

// File: doc/frame_rx_checker.md
FRAME_RX_CHECKER -- requirements
Module: frame_rx_checker

Interface
REQ-001 SHALL have parameter MIN_PAYLOAD, default 46: minimum legal payload bytes.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1500: maximum legal payload bytes.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the frame statistics counters.
REQ-004 SHALL have parameter PREAMBLE_LEN, default 7: number of 0x55 bytes expected before the SFD.
REQ-005 SHALL have ports clk (in, 1), the single clock, and rst_n (in, 1), the asynchronous active-low reset.
REQ-006 SHALL have ports s_data (in, 8), s_valid (in, 1), s_sop (in, 1), s_eop (in, 1) and s_ready (out, 1), forming the byte stream that starts at the preamble and ends at the last FCS byte.
REQ-007 SHALL have ports dest_mac (out, 48), src_mac (out, 48), ether_type (out, 16) and hdr_valid (out, 1), where hdr_valid is a one-cycle pulse when the header is captured.
REQ-008 SHALL have ports vlan_present (out, 1) and vlan_tci (out, 16).
REQ-009 SHALL have ports status_valid (out, 1), status_ready (in, 1), status_err (out, 6) and payload_len (out, 11).
- status_err bits: [0] preamble, [1] sfd, [2] runt, [3] giant, [4] crc, [5] truncated.
REQ-010 SHALL have ports frames_ok (out, CNT_WIDTH) and frames_err (out, CNT_WIDTH).

Function
REQ-011 SHALL accept a byte only when s_valid and s_ready are both high.
REQ-012 SHALL use states IDLE, PREAMBLE, SFD, DST, SRC, TYPE, VTAG, PAYLOAD and REPORT.
REQ-013 SHALL leave IDLE only on an accepted byte with s_sop high; that byte counts as preamble byte 0.
REQ-014 SHALL set the preamble error if any of the PREAMBLE_LEN bytes is not 0x55, and the sfd error if the following byte is not 0xD5; checking continues after either error.
REQ-015 SHALL capture DST and SRC MSB-first, 6 bytes each, then the 2 TYPE bytes.
REQ-016 SHALL pulse hdr_valid the cycle after the final TYPE byte, or the final VTAG byte when VLAN is active.
REQ-017 SHALL, in PAYLOAD, count bytes up to and including the s_eop byte; payload_len equals that count minus 4, saturating at 2047, and 0 if the count is below 4.
REQ-018 SHALL feed the CRC over DST through the end of the payload only, excluding the FCS, via a 4-byte delay line.
- FCS arrives crc_out[7:0] first.
- The crc error is set if the received FCS does not equal crc_out.
REQ-019 SHALL set the runt error when payload_len < MIN_PAYLOAD and the giant error when payload_len > MAX_PAYLOAD.
- The PAYLOAD byte counter stops at 2047.
REQ-020 SHALL set the truncated error on s_eop in any state before PAYLOAD, and on s_sop accepted in any state other than IDLE or REPORT.
- On that s_sop, the current frame is reported; the new frame is dropped.
REQ-021 SHALL enter REPORT after s_eop or an abort.
- status_valid is held high and outputs stable until status_ready is high.
- s_ready is low throughout REPORT.
- The state returns to IDLE the cycle after the handshake.
REQ-022 SHALL, on the status handshake, increment frames_ok if status_err is 0, otherwise frames_err; each counter saturates at all-ones.
REQ-023 SHALL hold s_ready high in every state except REPORT.
REQ-024 SHALL ignore accepted bytes in IDLE whose s_sop is low.

Reset
REQ-025 SHALL, while rst_n is low, force state IDLE, s_ready=0, hdr_valid=0, status_valid=0, and zero on all other outputs and counters.
REQ-026 SHALL drive s_ready=1 from the first clock edge after rst_n deasserts; a frame in flight at reset is discarded unreported.

Configuration
REQ-027 SHALL implement VLAN parsing only under the macro FRAME_RX_CHECKER_VLAN_EN.
- Defined: TYPE 0x8100 enters VTAG, which captures vlan_tci plus the 2-byte inner type into ether_type and sets vlan_present; the 4 tag bytes are in the CRC and excluded from payload_len.
- Undefined: VTAG does not exist, 0x8100 is treated as an ordinary type, and vlan_present and vlan_tci are tied to 0.

Structure
REQ-028 SHALL take the state encoding, the status_err bit indices and the constants 0x55, 0xD5 and 0x8100 from the shared package eth_pkg.
REQ-029 SHALL instantiate the existing crc32_gen as its only sub-module, reset through rst_n and a per-frame clear.

Verification
REQ-030 SHALL pass: 60-byte payload, good FCS, status_ready=1 -> status_err=0, payload_len=60, frames_ok=1.
REQ-031 SHALL pass: the REQ-030 frame with one FCS bit flipped -> status_err=0x10, frames_err=1.
REQ-032 SHALL pass: 20-byte payload -> runt bit set; 1501-byte payload -> giant bit set.
REQ-033 SHALL pass: s_eop on SRC byte 3 -> status_err=0x20, and no hdr_valid pulse.
REQ-034 SHALL pass: status_ready held low for 10 cycles -> s_ready=0 and status stable for 10 cycles, then IDLE one cycle after acceptance.
REQ-035 SHALL pass, with VLAN enabled: type 0x8100, TCI 0x6005, inner type 0x0800 -> vlan_tci=0x6005, ether_type=0x0800, and payload_len excludes the tag.
